// File: rtl/dac_pkg.sv
// ----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the dual-channel SPI DAC driver:
//   - FSM state encoding for dac_spi_driver
//   - DAC command and address nibbles
//   - helper that maps a memory channel onto its DAC address nibble
// ----------------------------------------------------------------------------
package dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] DAC_ADDR_A           = 4'b0000;
    localparam logic [3:0] DAC_ADDR_B           = 4'b0001;

    // Memory channel 0 feeds DAC output A, channel 1 feeds DAC output B.
    function automatic logic [3:0] dac_addr_nibble(input logic channel);
        return channel ? DAC_ADDR_B : DAC_ADDR_A;
    endfunction

endpackage

// File: rtl/dac_spi_driver_spi_shifter.sv
// ----------------------------------------------------------------------------
// spi_shifter
// Serialises one N-bit frame MSB first. SCK idles low, toggles every DIV clk
// cycles starting with a rising edge, and MOSI advances on each falling edge.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture frame and start shifting on this clock edge
//   frame      : frame to send
//   busy       : high while the shift continues past the current cycle;
//                low in the cycle whose closing edge is the N-th falling edge
//   sck, mosi  : SPI clock and data, both straight from flops
// ----------------------------------------------------------------------------
module spi_shifter #(
    parameter int N   = 32,
    parameter int DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] frame,
    output logic         busy,
    output logic         sck,
    output logic         mosi
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    logic          active_r;
    logic [CW-1:0] div_cnt_r;
    logic [BW-1:0] bit_cnt_r;
    logic [N-1:0]  sr_r;
    logic          sck_r;
    logic          mosi_r;

    logic tick_s;
    logic fall_s;
    logic final_s;

    // Decode half-period ticks, falling edges and the frame's final edge.
    always_comb begin
        tick_s  = active_r && (div_cnt_r == CW'(DIV - 1));
        fall_s  = tick_s && sck_r;
        final_s = fall_s && (bit_cnt_r == BW'(N - 1));
        // Dropping busy one cycle early lets the controller leave its shift
        // state on exactly the edge that ends the frame.
        busy    = active_r && !final_s;
    end

    // Divider, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r  <= 1'b0;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            sr_r      <= '0;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
        end else if (load) begin
            active_r  <= 1'b1;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            sr_r      <= frame;
            sck_r     <= 1'b0;
            mosi_r    <= frame[N-1];
        end else if (active_r) begin
            if (tick_s) begin
                div_cnt_r <= '0;
                sck_r     <= ~sck_r;
                if (sck_r) begin
                    // Falling edge: present the next bit (zeros after the last).
                    sr_r      <= sr_r << 1;
                    mosi_r    <= sr_r[N-2];
                    bit_cnt_r <= bit_cnt_r + BW'(1);
                    if (final_s) begin
                        active_r <= 1'b0;
                    end else begin
                        active_r <= 1'b1;
                    end
                end else begin
                    sr_r <= sr_r;
                end
            end else begin
                div_cnt_r <= div_cnt_r + CW'(1);
            end
        end else begin
            active_r <= 1'b0;
        end
    end

    assign sck  = sck_r;
    assign mosi = mosi_r;

endmodule

// File: rtl/dac_spi_driver.sv
// ----------------------------------------------------------------------------
// dac_spi_driver
// Walks the dual-channel sample memory (channel 0/1 per address), fetches one
// sample per frame and sends it to a dual-channel SPI DAC as a write-and-update
// command, alternating DAC output A and B.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   enable            : run request, sampled in IDLE and DONE
//   read              : one-cycle memory read strobe per frame
//   channel, address  : memory location being fetched
//   sample            : memory data, valid the cycle after read
//   dac_cs_n, dac_sck, dac_mosi : SPI pins (all registered)
//   frame_done        : one-cycle pulse after each completed frame
// ----------------------------------------------------------------------------
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int size    = 12,
    parameter int logsize = 4,
    parameter int N       = 32,
    parameter int DIV     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               read,
    output logic               channel,
    output logic [logsize-1:0] address,
    input  logic [size-1:0]    sample,
    output logic               dac_cs_n,
    output logic               dac_sck,
    output logic               dac_mosi,
    output logic               frame_done
);

    state_t             state_r;
    logic               read_r;
    logic               channel_r;
    logic [logsize-1:0] address_r;
    logic               cs_n_r;
    logic               frame_done_r;
    logic               done_cnt_r;

    logic [N-1:0]       frame_s;
    logic               load_s;
    logic               shift_busy_s;

    // Frame assembly: command, DAC address, sample, zero padding.
    always_comb begin
        frame_s                = '0;
        frame_s[N-1 -: 4]      = DAC_CMD_WRITE_UPDATE;
        frame_s[N-5 -: 4]      = dac_addr_nibble(channel_r);
        frame_s[N-9 -: size]   = sample;
        // The shifter captures the frame on the closing edge of WAIT, which is
        // what freezes the sample for the rest of the frame.
        load_s                 = (state_r == ST_WAIT);
    end

    spi_shifter #(
        .N   (N),
        .DIV (DIV)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .frame (frame_s),
        .busy  (shift_busy_s),
        .sck   (dac_sck),
        .mosi  (dac_mosi)
    );

    // Control FSM with registered memory strobes and chip select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            read_r       <= 1'b0;
            channel_r    <= 1'b0;
            address_r    <= '0;
            cs_n_r       <= 1'b1;
            frame_done_r <= 1'b0;
            done_cnt_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    cs_n_r       <= 1'b1;
                    if (enable) begin
                        state_r <= ST_FETCH;
                        read_r  <= 1'b1;
                    end else begin
                        read_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    read_r  <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    cs_n_r  <= 1'b0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!shift_busy_s) begin
                        state_r      <= ST_DONE;
                        cs_n_r       <= 1'b1;
                        frame_done_r <= 1'b1;
                        done_cnt_r   <= 1'b0;
                    end else begin
                        cs_n_r       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    frame_done_r <= 1'b0;
                    if (!done_cnt_r) begin
                        done_cnt_r <= 1'b1;
                    end else begin
                        // Advance to the next (address, channel) pair; the
                        // address moves on once both channels were sent.
                        channel_r <= ~channel_r;
                        if (channel_r) begin
                            address_r <= address_r + logsize'(1);
                        end else begin
                            address_r <= address_r;
                        end
                        if (enable) begin
                            state_r <= ST_FETCH;
                            read_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    read_r       <= 1'b0;
                    cs_n_r       <= 1'b1;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign read       = read_r;
    assign channel    = channel_r;
    assign address    = address_r;
    assign dac_cs_n   = cs_n_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_dac_spi_driver.sv
// ----------------------------------------------------------------------------
// tb_dac_spi_driver
// Bench for dac_spi_driver: a default-parameter instance driven by a memory
// model, plus a small DIV=1/N=24/size=8 instance. A negedge monitor pushes
// expected frames (from its own address/channel model) whenever the memory is
// read and records the frames actually observed on the SPI pins.
// ----------------------------------------------------------------------------
module tb_dac_spi_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        read;
    logic        channel;
    logic [3:0]  address;
    logic [11:0] sample = 12'h000;
    logic        dac_cs_n, dac_sck, dac_mosi, frame_done;

    logic        en2 = 1'b0;
    logic        read2, channel2;
    logic [3:0]  address2;
    logic [7:0]  sample2 = 8'h5A;
    logic        cs2, sck2, mosi2, done2;

    int vectors = 0;
    int miscompares = 0;

    logic mon_en = 1'b0;
    logic toggle_mode = 1'b0;

    always #5 clk = ~clk;

    dac_spi_driver u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .read(read), .channel(channel),
        .address(address), .sample(sample), .dac_cs_n(dac_cs_n), .dac_sck(dac_sck),
        .dac_mosi(dac_mosi), .frame_done(frame_done)
    );

    dac_spi_driver #(.size(8), .logsize(4), .N(24), .DIV(1)) u_small (
        .clk(clk), .rst_n(rst_n), .enable(en2), .read(read2), .channel(channel2),
        .address(address2), .sample(sample2), .dac_cs_n(cs2), .dac_sck(sck2),
        .dac_mosi(mosi2), .frame_done(done2)
    );

    function automatic logic [11:0] mem_f(input logic [3:0] a, input logic c);
        if (a == 4'd0 && c == 1'b0) return 12'hABC;
        return {a, 3'b101, c, ~a};
    endfunction

    // Memory model: data valid the cycle after read; toggle mode ignores read.
    always @(posedge clk) begin
        if (toggle_mode) sample <= (sample == 12'h000) ? 12'hFFF : 12'h000;
        else if (read)   sample <= mem_f(address, channel);
    end

    // Monitor state (written only by the monitor below).
    logic [31:0] exp_frame_q[$];
    logic [4:0]  exp_pair_q[$];
    logic [4:0]  obs_pair_q[$];
    logic [31:0] obs_frame_q[$];
    int          obs_bits_q[$];
    int          obs_cslow_q[$];
    int          fall_lat_q[$];
    logic [3:0]  exp_addr;
    logic        exp_ch;
    logic [11:0] d_nxt;
    logic [31:0] shreg;
    int          bitcnt, cs_run, since_read, fd_cnt, cyc;
    logic        prev_sck, prev_cs;
    logic [23:0] shreg2;
    int          bitcnt2, cs_run2;
    logic        prev_sck2, prev_cs2;
    logic [23:0] obs2_q[$];
    int          obs2_bits_q[$], obs2_cslow_q[$], rd2_cyc_q[$], sck2_cyc_q[$];

    // Scoreboard producer and SPI frame capture for both instances.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!mon_en) begin
            exp_frame_q.delete(); exp_pair_q.delete(); obs_pair_q.delete();
            obs_frame_q.delete(); obs_bits_q.delete(); obs_cslow_q.delete();
            fall_lat_q.delete(); obs2_q.delete(); obs2_bits_q.delete();
            obs2_cslow_q.delete(); rd2_cyc_q.delete(); sck2_cyc_q.delete();
            exp_addr = 4'd0; exp_ch = 1'b0; shreg = 32'd0; bitcnt = 0;
            cs_run = 0; since_read = 100; fd_cnt = 0; prev_sck = 1'b0; prev_cs = 1'b1;
            shreg2 = 24'd0; bitcnt2 = 0; cs_run2 = 0; prev_sck2 = 1'b0; prev_cs2 = 1'b1;
        end else begin
            if (read) begin
                d_nxt = toggle_mode ? ((sample == 12'h000) ? 12'hFFF : 12'h000)
                                    : mem_f(exp_addr, exp_ch);
                exp_frame_q.push_back({4'h3, (exp_ch ? 4'h1 : 4'h0), d_nxt, 12'h000});
                exp_pair_q.push_back({exp_addr, exp_ch});
                obs_pair_q.push_back({address, channel});
                if (exp_ch) exp_addr = exp_addr + 4'd1;
                exp_ch = ~exp_ch;
                since_read = 0;
            end else begin
                since_read = since_read + 1;
            end
            if (prev_cs && !dac_cs_n) begin
                fall_lat_q.push_back(since_read);
                shreg = 32'd0; bitcnt = 0; cs_run = 0;
            end
            if (!dac_cs_n) begin
                cs_run = cs_run + 1;
                if (dac_sck && !prev_sck) begin
                    shreg = {shreg[30:0], dac_mosi};
                    bitcnt = bitcnt + 1;
                end
            end
            if (!prev_cs && dac_cs_n) begin
                obs_frame_q.push_back(shreg);
                obs_bits_q.push_back(bitcnt);
                obs_cslow_q.push_back(cs_run);
            end
            if (frame_done) fd_cnt = fd_cnt + 1;
            prev_sck = dac_sck; prev_cs = dac_cs_n;

            if (read2) rd2_cyc_q.push_back(cyc);
            if (prev_cs2 && !cs2) begin shreg2 = 24'd0; bitcnt2 = 0; cs_run2 = 0; end
            if (!cs2) begin
                cs_run2 = cs_run2 + 1;
                if (sck2 && !prev_sck2) begin
                    shreg2 = {shreg2[22:0], mosi2};
                    bitcnt2 = bitcnt2 + 1;
                    sck2_cyc_q.push_back(cyc);
                end
            end
            if (!prev_cs2 && cs2) begin
                obs2_q.push_back(shreg2);
                obs2_bits_q.push_back(bitcnt2);
                obs2_cslow_q.push_back(cs_run2);
            end
            prev_sck2 = sck2; prev_cs2 = cs2;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; mon_en = 1'b0;
        step(3);
        rst_n = 1'b1; mon_en = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int k = 0; k < budget && obs_frame_q.size() < n; k++) step(1);
    endtask

    task automatic wait_read(input int budget);
        for (int k = 0; k < budget && obs_pair_q.size() < 1; k++) step(1);
    endtask

    task automatic test_reset();
        en = 1'b0; en2 = 1'b0;
        rst_n = 1'b0; mon_en = 1'b0;
        step(2);
        vectors++; if (read !== 1'b0)    begin miscompares++; $display("FAIL rst_read: got %b want 0", read); end
        vectors++; if (channel !== 1'b0) begin miscompares++; $display("FAIL rst_channel: got %b want 0", channel); end
        vectors++; if (address !== 4'd0) begin miscompares++; $display("FAIL rst_address: got %h want 0", address); end
        vectors++; if (dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n: got %b want 1", dac_cs_n); end
        vectors++; if (dac_sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b want 0", dac_sck); end
        vectors++; if (dac_mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b want 0", dac_mosi); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        vectors++; if (cs2 !== 1'b1 || sck2 !== 1'b0 || read2 !== 1'b0) begin miscompares++; $display("FAIL rst_small: got cs %b sck %b read %b want 1 0 0", cs2, sck2, read2); end
        rst_n = 1'b1; mon_en = 1'b1;
        step(5);
        vectors++; if (read !== 1'b0 || dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL idle_hold: got read %b cs_n %b want 0 1", read, dac_cs_n); end
    endtask

    task automatic test_single_frame();
        apply_reset();
        en = 1'b1;
        wait_read(10);
        en = 1'b0;
        wait_frames(1, 200);
        step(5);
        vectors++; if (obs_frame_q.size() !== 1 || obs_pair_q.size() !== 1) begin
            miscompares++; $display("FAIL single_count: got frames %0d reads %0d want 1 1", obs_frame_q.size(), obs_pair_q.size());
        end else begin
            vectors++; if (obs_frame_q[0] !== exp_frame_q[0]) begin miscompares++; $display("FAIL single_frame: got %h want %h", obs_frame_q[0], exp_frame_q[0]); end
            vectors++; if (obs_frame_q[0] !== 32'h30ABC000) begin miscompares++; $display("FAIL single_value: got %h want 30abc000", obs_frame_q[0]); end
            vectors++; if (obs_bits_q[0] !== 32) begin miscompares++; $display("FAIL single_bits: got %0d want 32", obs_bits_q[0]); end
            vectors++; if (obs_cslow_q[0] !== 128) begin miscompares++; $display("FAIL single_cs_low: got %0d want 128", obs_cslow_q[0]); end
            vectors++; if (fall_lat_q[0] !== 2) begin miscompares++; $display("FAIL single_cs_latency: got %0d want 2", fall_lat_q[0]); end
            vectors++; if (obs_pair_q[0] !== exp_pair_q[0]) begin miscompares++; $display("FAIL single_pair: got %h want %h", obs_pair_q[0], exp_pair_q[0]); end
        end
        vectors++; if (fd_cnt !== 1) begin miscompares++; $display("FAIL single_frame_done: got %0d want 1", fd_cnt); end
        vectors++; if (channel !== 1'b1 || address !== 4'd0) begin miscompares++; $display("FAIL single_next: got ch %b addr %h want 1 0", channel, address); end
    endtask

    task automatic test_continuous();
        apply_reset();
        en = 1'b1;
        wait_frames(33, 33 * 132 + 50);
        en = 1'b0;
        step(300);
        vectors++; if (obs_frame_q.size() < 33 || obs_frame_q.size() !== obs_pair_q.size()) begin
            miscompares++; $display("FAIL cont_count: got frames %0d reads %0d want >=33 equal", obs_frame_q.size(), obs_pair_q.size());
        end else begin
            for (int i = 0; i < obs_frame_q.size(); i++) begin
                vectors++; if (obs_pair_q[i] !== exp_pair_q[i]) begin miscompares++; $display("FAIL cont_pair[%0d]: got %h want %h", i, obs_pair_q[i], exp_pair_q[i]); end
                vectors++; if (obs_frame_q[i] !== exp_frame_q[i]) begin miscompares++; $display("FAIL cont_frame[%0d]: got %h want %h", i, obs_frame_q[i], exp_frame_q[i]); end
                vectors++; if (obs_bits_q[i] !== 32) begin miscompares++; $display("FAIL cont_bits[%0d]: got %0d want 32", i, obs_bits_q[i]); end
            end
            vectors++; if (obs_pair_q[31] !== 5'b11111) begin miscompares++; $display("FAIL cont_last: got %h want 1f", obs_pair_q[31]); end
            vectors++; if (obs_pair_q[32] !== 5'b00000) begin miscompares++; $display("FAIL cont_wrap: got %h want 00", obs_pair_q[32]); end
            vectors++; if (obs_frame_q[1][27:24] !== 4'h1) begin miscompares++; $display("FAIL cont_nibble_b: got %h want 1", obs_frame_q[1][27:24]); end
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        en = 1'b1;
        for (int k = 0; k < 20 && dac_cs_n !== 1'b0; k++) step(1);
        step(39);
        en = 1'b0;
        wait_frames(1, 200);
        step(300);
        vectors++; if (obs_frame_q.size() !== 1 || obs_pair_q.size() !== 1) begin
            miscompares++; $display("FAIL drop_count: got frames %0d reads %0d want 1 1", obs_frame_q.size(), obs_pair_q.size());
        end else begin
            vectors++; if (obs_bits_q[0] !== 32) begin miscompares++; $display("FAIL drop_bits: got %0d want 32", obs_bits_q[0]); end
            vectors++; if (obs_frame_q[0] !== exp_frame_q[0]) begin miscompares++; $display("FAIL drop_frame: got %h want %h", obs_frame_q[0], exp_frame_q[0]); end
        end
        vectors++; if (dac_cs_n !== 1'b1 || read !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got cs_n %b read %b want 1 0", dac_cs_n, read); end
        vectors++; if (channel !== 1'b1 || address !== 4'd0) begin miscompares++; $display("FAIL drop_advance: got ch %b addr %h want 1 0", channel, address); end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        en = 1'b1;
        for (int k = 0; k < 120 && bitcnt < 17; k++) step(1);
        vectors++; if (bitcnt !== 17) begin miscompares++; $display("FAIL mid_reach17: got %0d want 17", bitcnt); end
        rst_n = 1'b0; mon_en = 1'b0;
        step(1);
        vectors++; if (dac_cs_n !== 1'b1 || dac_sck !== 1'b0 || dac_mosi !== 1'b0) begin
            miscompares++; $display("FAIL mid_spi_reset: got cs_n %b sck %b mosi %b want 1 0 0", dac_cs_n, dac_sck, dac_mosi);
        end
        vectors++; if (read !== 1'b0 || channel !== 1'b0 || address !== 4'd0 || frame_done !== 1'b0) begin
            miscompares++; $display("FAIL mid_ctl_reset: got read %b ch %b addr %h done %b want 0 0 0 0", read, channel, address, frame_done);
        end
        step(1);
        rst_n = 1'b1; mon_en = 1'b1;
        wait_read(10);
        en = 1'b0;
        wait_frames(1, 200);
        vectors++; if (obs_frame_q.size() !== 1) begin
            miscompares++; $display("FAIL mid_restart_count: got %0d want 1", obs_frame_q.size());
        end else begin
            vectors++; if (obs_pair_q[0] !== 5'b00000) begin miscompares++; $display("FAIL mid_restart_pair: got %h want 00", obs_pair_q[0]); end
            vectors++; if (obs_frame_q[0] !== exp_frame_q[0]) begin miscompares++; $display("FAIL mid_restart_frame: got %h want %h", obs_frame_q[0], exp_frame_q[0]); end
        end
        step(5);
    endtask

    task automatic test_sample_hold();
        toggle_mode = 1'b1;
        apply_reset();
        en = 1'b1;
        wait_read(10);
        en = 1'b0;
        wait_frames(1, 200);
        vectors++; if (obs_frame_q.size() !== 1) begin
            miscompares++; $display("FAIL hold_count: got %0d want 1", obs_frame_q.size());
        end else begin
            vectors++; if (obs_frame_q[0] !== exp_frame_q[0]) begin miscompares++; $display("FAIL hold_frame: got %h want %h", obs_frame_q[0], exp_frame_q[0]); end
        end
        toggle_mode = 1'b0;
        step(5);
    endtask

    task automatic test_small_config();
        logic [23:0] exp2_q[$];
        apply_reset();
        en2 = 1'b1;
        exp2_q.push_back(24'h305A00);
        exp2_q.push_back(24'h315A00);
        for (int k = 0; k < 200 && obs2_q.size() < 2; k++) step(1);
        en2 = 1'b0;
        step(60);
        vectors++; if (obs2_q.size() < 2 || rd2_cyc_q.size() < 2 || sck2_cyc_q.size() < 2) begin
            miscompares++; $display("FAIL small_count: got frames %0d reads %0d want >=2", obs2_q.size(), rd2_cyc_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++; if (obs2_q[i] !== exp2_q[i]) begin miscompares++; $display("FAIL small_frame[%0d]: got %h want %h", i, obs2_q[i], exp2_q[i]); end
                vectors++; if (obs2_bits_q[i] !== 24) begin miscompares++; $display("FAIL small_bits[%0d]: got %0d want 24", i, obs2_bits_q[i]); end
                vectors++; if (obs2_cslow_q[i] !== 48) begin miscompares++; $display("FAIL small_cs_low[%0d]: got %0d want 48", i, obs2_cslow_q[i]); end
            end
            vectors++; if (rd2_cyc_q[1] - rd2_cyc_q[0] !== 52) begin miscompares++; $display("FAIL small_period: got %0d want 52", rd2_cyc_q[1] - rd2_cyc_q[0]); end
            vectors++; if (sck2_cyc_q[1] - sck2_cyc_q[0] !== 2) begin miscompares++; $display("FAIL small_sck_period: got %0d want 2", sck2_cyc_q[1] - sck2_cyc_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_enable_drop();
        test_reset_mid_frame();
        test_sample_hold();
        test_small_config();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
